// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready load handshake and registered serial outputs.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PISO_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             out_n, valid_n, last_n, busy_n, ready_n;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par, par_n;
`endif

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    assign accept = in_valid & in_ready;

    // Outputs are computed one cycle ahead so every port leaves a flop; cnt tracks the bit now on ser_out.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        out_n   = 1'b0;
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
        ready_n = 1'b0;
`ifdef PISO_PARITY_EN
        par_n   = par;
`endif
        if (accept) begin
            state_n = SHIFT;
            cnt_n   = '0;
            shreg_n = shift_once(in_data);
            out_n   = head_bit(in_data);
            valid_n = 1'b1;
            busy_n  = 1'b1;
`ifdef PISO_PARITY_EN
            par_n   = ^in_data;
`endif
        end else begin
            unique case (state)
                IDLE: ready_n = 1'b1;
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
`ifdef PISO_PARITY_EN
                        state_n = PARITY;
                        out_n   = par;
                        valid_n = 1'b1;
                        last_n  = 1'b1;
                        busy_n  = 1'b1;
                        ready_n = 1'b1;
`else
                        state_n = IDLE;
                        ready_n = 1'b1;
`endif
                    end else begin
                        cnt_n   = cnt + CW'(1);
                        out_n   = head_bit(shreg);
                        shreg_n = shift_once(shreg);
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
`ifndef PISO_PARITY_EN
                        last_n  = (cnt == CNT_PENULT);
                        ready_n = (cnt == CNT_PENULT);
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end
`endif
                default: begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
`ifdef PISO_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            ser_out   <= out_n;
            ser_valid <= valid_n;
            ser_last  <= last_n;
            busy      <= busy_n;
            in_ready  <= ready_n;
`ifdef PISO_PARITY_EN
            par       <= par_n;
`endif
        end
    end

endmodule
